// File: rtl/cpu_boot_pkg.sv
// Shared types, sizes and byte-lane helper for the CPU boot-load path.
package cpu_boot_pkg;

  localparam int IMEM_DEPTH = 256;
  localparam int IMEM_AW    = 8;
  localparam int DMEM_BYTES = 32;
  localparam int DMEM_AW    = 5;

  localparam logic [IMEM_AW-1:0] CLR_LAST  = IMEM_AW'(IMEM_DEPTH - 1);
  localparam logic [IMEM_AW-1:0] DMEM_END  = IMEM_AW'(DMEM_BYTES);
  localparam logic [1:0]         LAST_LANE = 2'd3;

  typedef enum logic [2:0] {
    CLR  = 3'd0,
    HDR  = 3'd1,
    WORD = 3'd2,
    NVAL = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } state_e;

  // Little-endian placement: lane 0 lands in bits [7:0], lane 3 in [31:24].
  function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  data);
    logic [31:0] res;
    res = word;
    res[{lane, 3'b000} +: 8] = data;
    return res;
  endfunction

endpackage

// File: rtl/byte_to_word_assembler.sv
// Packs a byte stream into 32-bit little-endian words with a one-cycle valid pulse.
module byte_to_word_assembler
  import cpu_boot_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic        last_lane_o,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  lane_r;
  logic [31:0] part_r;
  logic [31:0] word_r;
  logic        valid_r;

  // Accumulate lanes; the finished word and its valid pulse are registered together.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      lane_r  <= 2'd0;
      part_r  <= 32'h0000_0000;
      word_r  <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (en_i) begin
        if (lane_r == LAST_LANE) begin
          word_r  <= lane_insert(part_r, lane_r, byte_i);
          valid_r <= 1'b1;
          part_r  <= 32'h0000_0000;
          lane_r  <= 2'd0;
        end else begin
          part_r <= lane_insert(part_r, lane_r, byte_i);
          lane_r <= lane_r + 2'd1;
        end
      end
    end
  end

  assign last_lane_o  = (lane_r == LAST_LANE);
  assign word_o       = word_r;
  assign word_valid_o = valid_r;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: clears imem/dmem, loads program words and operand n, then releases the CPU.
module imem_loader
  import cpu_boot_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               byte_valid_i,
  input  logic [7:0]         byte_data_i,
  output logic               byte_ready_o,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [31:0]        imem_data_o,
  output logic               dmem_we_o,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic [7:0]         dmem_data_o,
  output logic               cpu_rst_o,
  output logic               cpu_start_o,
  output logic               busy_o,
  output logic               err_o
);

  state_e             state_r;
  logic [IMEM_AW-1:0] cnt_r;
  logic [IMEM_AW-1:0] idx_r;
  logic [7:0]         n_r;
  logic               imem_we_r;
  logic [IMEM_AW-1:0] imem_addr_r;
  logic               dmem_we_r;
  logic [DMEM_AW-1:0] dmem_addr_r;
  logic [7:0]         dmem_data_r;
  logic               ready_r;
  logic               busy_r;
  logic               err_r;
  logic               cpu_rst_r;
  logic               cpu_start_r;

  logic               accept_s;
  logic               last_lane_s;
  logic [31:0]        word_s;
  logic               word_valid_s;

  assign accept_s = byte_valid_i & ready_r;

  byte_to_word_assembler u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (accept_s & (state_r == WORD)),
    .byte_i       (byte_data_i),
    .last_lane_o  (last_lane_s),
    .word_o       (word_s),
    .word_valid_o (word_valid_s)
  );

  // Load sequencer; every handshake and strobe output is a register set here.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r     <= CLR;
      cnt_r       <= {IMEM_AW{1'b0}};
      idx_r       <= {IMEM_AW{1'b0}};
      n_r         <= 8'd0;
      imem_we_r   <= 1'b0;
      imem_addr_r <= {IMEM_AW{1'b0}};
      dmem_we_r   <= 1'b0;
      dmem_addr_r <= {DMEM_AW{1'b0}};
      dmem_data_r <= 8'd0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b1;
      err_r       <= 1'b0;
      cpu_rst_r   <= 1'b0;
      cpu_start_r <= 1'b0;
    end else begin
      imem_we_r <= 1'b0;
      dmem_we_r <= 1'b0;
      case (state_r)
        CLR: begin
          imem_we_r   <= 1'b1;
          imem_addr_r <= cnt_r;
          if (cnt_r < DMEM_END) begin
            dmem_we_r   <= 1'b1;
            dmem_addr_r <= cnt_r[DMEM_AW-1:0];
            dmem_data_r <= 8'd0;
          end
          if (cnt_r == CLR_LAST) begin
            state_r <= HDR;
            ready_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + {{(IMEM_AW-1){1'b0}}, 1'b1};
          end
        end
        HDR: begin
          if (accept_s) begin
            if (byte_data_i == 8'd0) begin
              state_r <= ERR;
              err_r   <= 1'b1;
              ready_r <= 1'b0;
              busy_r  <= 1'b0;
            end else begin
              n_r     <= byte_data_i;
              idx_r   <= {IMEM_AW{1'b0}};
              state_r <= WORD;
            end
          end
        end
        WORD: begin
          // The assembler presents the word one cycle later; latch its address now.
          if (accept_s && last_lane_s) begin
            imem_addr_r <= idx_r;
            if (idx_r == IMEM_AW'(n_r - 8'd1)) begin
              state_r <= NVAL;
            end else begin
              idx_r <= idx_r + {{(IMEM_AW-1){1'b0}}, 1'b1};
            end
          end
        end
        NVAL: begin
          if (accept_s) begin
            dmem_we_r   <= 1'b1;
            dmem_addr_r <= {DMEM_AW{1'b0}};
            dmem_data_r <= byte_data_i;
            state_r     <= RUN;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        RUN: begin
          cpu_rst_r   <= 1'b1;
          cpu_start_r <= 1'b1;
        end
        ERR: begin
          err_r       <= 1'b1;
          ready_r     <= 1'b0;
          busy_r      <= 1'b0;
          cpu_rst_r   <= 1'b0;
          cpu_start_r <= 1'b0;
        end
        default: begin
          state_r     <= ERR;
          err_r       <= 1'b1;
          ready_r     <= 1'b0;
          busy_r      <= 1'b0;
          cpu_rst_r   <= 1'b0;
          cpu_start_r <= 1'b0;
        end
      endcase
    end
  end

  // Merge the clear-phase strobe with the assembler's registered word pulse.
  always_comb begin
    imem_we_o   = imem_we_r | word_valid_s;
    imem_addr_o = imem_addr_r;
    if (word_valid_s) begin
      imem_data_o = word_s;
    end else begin
      imem_data_o = 32'h0000_0000;
    end
  end

  assign byte_ready_o = ready_r;
  assign dmem_we_o    = dmem_we_r;
  assign dmem_addr_o  = dmem_addr_r;
  assign dmem_data_o  = dmem_data_r;
  assign cpu_rst_o    = cpu_rst_r;
  assign cpu_start_o  = cpu_start_r;
  assign busy_o       = busy_r;
  assign err_o        = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a phase-level reference model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        dmem_we;
  logic [4:0]  dmem_addr;
  logic [7:0]  dmem_data;
  logic        cpu_rst;
  logic        cpu_start;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_ready_o (byte_ready),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_data_o  (imem_data),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_data_o  (dmem_data),
    .cpu_rst_o    (cpu_rst),
    .cpu_start_o  (cpu_start),
    .busy_o       (busy),
    .err_o        (err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (phase + byte queue) ----------------
  localparam int P_CLR = 0, P_HDR = 1, P_WORD = 2, P_NVAL = 3, P_RUN = 4, P_ERR = 5;
  int          m_ph;
  int          m_clr;
  int          m_n;
  int          m_idx;
  logic [7:0]  m_pend[$];
  logic [31:0] m_imem[256];
  logic [7:0]  m_dmem[32];
  bit          chk_en = 1'b0;
  logic        e_ready, e_busy, e_err, e_crst, e_start, e_iwe, e_dwe;
  logic [7:0]  e_iaddr;
  logic [31:0] e_idata;
  logic [4:0]  e_daddr;
  logic [7:0]  e_ddata;

  always @(posedge clk) begin : model
    bit acc;
    if (!rst) begin
      chk_en = 1'b1;
      m_ph = P_CLR; m_clr = 0; m_n = 0; m_idx = 0;
      m_pend.delete();
      e_ready = 1'b0; e_busy = 1'b1; e_err = 1'b0;
      e_crst = 1'b0; e_start = 1'b0; e_iwe = 1'b0; e_dwe = 1'b0;
    end else begin
      acc = byte_valid && e_ready;
      e_iwe = 1'b0;
      e_dwe = 1'b0;
      case (m_ph)
        P_CLR: begin
          e_iwe = 1'b1; e_iaddr = 8'(m_clr); e_idata = 32'h0;
          if (m_clr < 32) begin
            e_dwe = 1'b1; e_daddr = 5'(m_clr); e_ddata = 8'h00;
          end
          if (m_clr == 255) m_ph = P_HDR;
          else m_clr++;
        end
        P_HDR: if (acc) begin
          if (byte_data == 8'd0) m_ph = P_ERR;
          else begin m_n = int'(byte_data); m_idx = 0; m_pend.delete(); m_ph = P_WORD; end
        end
        P_WORD: if (acc) begin
          m_pend.push_back(byte_data);
          if (m_pend.size() == 4) begin
            e_iwe = 1'b1; e_iaddr = 8'(m_idx);
            e_idata = {m_pend[3], m_pend[2], m_pend[1], m_pend[0]};
            m_pend.delete();
            if (m_idx == m_n - 1) m_ph = P_NVAL;
            else m_idx++;
          end
        end
        P_NVAL: if (acc) begin
          e_dwe = 1'b1; e_daddr = 5'd0; e_ddata = byte_data;
          m_ph = P_RUN;
        end
        P_RUN: begin e_crst = 1'b1; e_start = 1'b1; end
        default: ;
      endcase
      if (e_iwe) m_imem[e_iaddr] = e_idata;
      if (e_dwe) m_dmem[e_daddr] = e_ddata;
      e_ready = (m_ph == P_HDR) || (m_ph == P_WORD) || (m_ph == P_NVAL);
      e_busy  = (m_ph <= P_NVAL);
      e_err   = (m_ph == P_ERR);
    end
  end

  // ---------------- per-cycle compare + shadow memories ----------------
  logic [31:0] dut_imem[256];
  logic [7:0]  dut_dmem[32];
  int          n_iw = 0;
  int          n_dw = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("byte_ready", 32'(byte_ready), 32'(e_ready));
      chk("busy",       32'(busy),       32'(e_busy));
      chk("err",        32'(err),        32'(e_err));
      chk("cpu_rst",    32'(cpu_rst),    32'(e_crst));
      chk("cpu_start",  32'(cpu_start),  32'(e_start));
      chk("imem_we",    32'(imem_we),    32'(e_iwe));
      chk("dmem_we",    32'(dmem_we),    32'(e_dwe));
      if (e_iwe) begin
        chk("imem_addr", 32'(imem_addr), 32'(e_iaddr));
        chk("imem_data", imem_data, e_idata);
      end
      if (e_dwe) begin
        chk("dmem_addr", 32'(dmem_addr), 32'(e_daddr));
        chk("dmem_data", 32'(dmem_data), 32'(e_ddata));
      end
    end
    if (imem_we === 1'b1) begin dut_imem[imem_addr] = imem_data; n_iw++; end
    if (dmem_we === 1'b1) begin dut_dmem[dmem_addr] = dmem_data; n_dw++; end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    byte_valid = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    rst = 1'b1;
  endtask

  task automatic wait_clear();
    int cyc, iw0, dw0;
    cyc = 0; iw0 = n_iw; dw0 = n_dw;
    while (!byte_ready && cyc < 400) begin
      step();
      cyc++;
    end
    chk("clr_cycles", 32'(cyc), 32'd256);
    chk("clr_imem_writes", 32'(n_iw - iw0), 32'd256);
    chk("clr_dmem_writes", 32'(n_dw - dw0), 32'd32);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    repeat (gap) begin
      byte_valid = 1'b0;
      byte_data = 8'($urandom);
      step();
    end
    byte_valid = 1'b1;
    byte_data = b;
    acc = 1'b0;
    for (int t = 0; t < 200 && !acc; t++) begin
      acc = byte_ready;
      step();
    end
    byte_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gapmax);
    for (int l = 0; l < 4; l++) send_byte(w[8*l +: 8], $urandom_range(0, gapmax));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int iw0;
    logic [31:0] wexp[8];
    logic [7:0]  nexp;
    int          nw;

    // Clear sequence after reset, then the reference program N=2, n=5.
    do_reset(3);
    wait_clear();
    send_byte(8'd2, 0);
    send_word(32'h2008_0005, 2);
    send_word(32'h0000_0000, 2);
    send_byte(8'd5, 1);
    chk("nval_write_cycle", 32'(dmem_we), 32'd1);
    chk("start_not_yet", 32'(cpu_start), 32'd0);
    step();
    chk("start_after_two_edges", 32'(cpu_start), 32'd1);
    chk("cpu_rst_released", 32'(cpu_rst), 32'd1);
    chk("busy_low_in_run", 32'(busy), 32'd0);
    chk("imem0", dut_imem[0], 32'h2008_0005);
    chk("imem1", dut_imem[1], 32'h0000_0000);
    chk("dmem0", 32'(dut_dmem[0]), 32'h05);
    chk("model_imem0", m_imem[0], 32'h2008_0005);

    // Bytes offered in RUN must be ignored.
    iw0 = n_iw + n_dw;
    byte_valid = 1'b1;
    byte_data = 8'hFF;
    repeat (10) step();
    byte_valid = 1'b0;
    chk("run_no_writes", 32'(n_iw + n_dw - iw0), 32'd0);
    chk("run_start_held", 32'(cpu_start), 32'd1);
    chk("run_ready_low", 32'(byte_ready), 32'd0);

    // Same stream with a 3-cycle valid gap between lanes 1 and 2.
    do_reset(2);
    wait_clear();
    send_byte(8'd2, 0);
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    iw0 = n_iw;
    send_byte(8'h08, 3);
    chk("gap_no_imem_we", 32'(n_iw - iw0), 32'd0);
    send_byte(8'h20, 0);
    send_word(32'h0000_0000, 0);
    send_byte(8'd5, 0);
    repeat (2) step();
    chk("gap_imem0", dut_imem[0], 32'h2008_0005);
    chk("gap_start", 32'(cpu_start), 32'd1);

    // Header N=0 is an error until the next reset.
    do_reset(2);
    wait_clear();
    send_byte(8'd0, 0);
    chk("err_set", 32'(err), 32'd1);
    chk("err_ready_low", 32'(byte_ready), 32'd0);
    byte_valid = 1'b1;
    byte_data = 8'h11;
    repeat (5) step();
    byte_valid = 1'b0;
    chk("err_held", 32'(err), 32'd1);
    chk("err_no_start", 32'(cpu_start), 32'd0);
    do_reset(1);
    wait_clear();

    // Reset mid-WORD discards the partial word; a fresh load then succeeds.
    send_byte(8'd1, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    do_reset(1);
    wait_clear();
    send_byte(8'd1, 0);
    send_word(32'hDEAD_BEEF, 1);
    send_byte(8'd7, 0);
    repeat (2) step();
    chk("abort_imem0", dut_imem[0], 32'hDEAD_BEEF);
    chk("abort_dmem0", 32'(dut_dmem[0]), 32'h07);
    chk("model_abort_imem0", m_imem[0], 32'hDEAD_BEEF);

    // Randomized loads.
    for (int r = 0; r < 3; r++) begin
      do_reset($urandom_range(1, 3));
      wait_clear();
      nw = $urandom_range(1, 8);
      send_byte(8'(nw), $urandom_range(0, 3));
      for (int i = 0; i < nw; i++) begin
        wexp[i] = $urandom;
        send_word(wexp[i], 3);
      end
      nexp = 8'($urandom);
      send_byte(nexp, $urandom_range(0, 3));
      repeat (3) step();
      for (int i = 0; i < nw; i++) chk("rand_imem", dut_imem[i], wexp[i]);
      chk("rand_dmem0", 32'(dut_dmem[0]), 32'(nexp));
      chk("rand_start", 32'(cpu_start), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
